// File: rtl/wm_seq_pkg.sv
// Shared types and width helpers for the watermark frame sequencer.
package wm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VS,
    HW,
    DATA,
    DONE
  } state_t;

  // Bit width for a counter ranging over 0..n-1. Never returns zero, so
  // degenerate sizes such as a single-row image still get a real port.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wm_delay_cnt.sv
// Loadable down-counter with terminal-count flag; times the VSYNC and HSYNC blanking intervals.
module wm_delay_cnt
  import wm_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/wm_frame_seq.sv
// Frame sequencer: VSYNC start-up, per-row HSYNC blanking, then two pixels per accepted cycle
// with a continuously wrapping watermark bit index; start/stall/abort capable.
module wm_frame_seq
  import wm_seq_pkg::*;
#(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int WM_BITS        = 64
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   VSYNC,
  output logic                   HSYNC,
  output logic                   pix_valid,
  output logic [cw(HEIGHT)-1:0]  row,
  output logic [cw(WIDTH)-1:0]   col,
  output logic [cw(WM_BITS)-1:0] wm_idx,
  output logic                   embed_en,
  output logic                   ctrl_done
);

  localparam int RW = cw(HEIGHT);
  localparam int CW = cw(WIDTH);
  localparam int WW = cw(WM_BITS);
  localparam int DW = cw(max2(START_UP_DELAY, HSYNC_DELAY) + 1);

  // Counter load values are "cycles - 1" because terminal count is itself one cycle.
  localparam logic [DW-1:0] VS_LD    = DW'((START_UP_DELAY > 0) ? START_UP_DELAY - 1 : 0);
  localparam logic [DW-1:0] HW_LD    = DW'((HSYNC_DELAY > 0) ? HSYNC_DELAY - 1 : 0);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 2);
  localparam logic [CW-1:0] COL_STEP = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [WW-1:0] WM_LAST  = WW'(WM_BITS - 1);

  if ((WIDTH % 2) != 0) begin : g_width_chk
    $error("wm_frame_seq: WIDTH must be even");
  end

  state_t          state, state_nx;
  logic [RW-1:0]   row_nx;
  logic [CW-1:0]   col_nx;
  logic [WW-1:0]   wm_nx;
  logic            cnt_load, cnt_en, cnt_tc;
  logic [DW-1:0]   cnt_val;
  logic            accept;

  wm_delay_cnt #(
    .CNT_W(DW)
  ) u_dly (
    .clk     (HCLK),
    .rst     (HRESET),
    .load    (cnt_load),
    .load_val(cnt_val),
    .en      (cnt_en),
    .tc      (cnt_tc)
  );

  assign accept = pix_valid & out_ready;

  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    wm_nx    = wm_idx;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;

    case (state)
      IDLE: begin
        if (start) begin
          row_nx = '0;
          col_nx = '0;
          wm_nx  = '0;
          if (START_UP_DELAY > 0) begin
            state_nx = VS;
            cnt_load = 1'b1;
            cnt_val  = VS_LD;
          end else if (HSYNC_DELAY > 0) begin
            state_nx = HW;
            cnt_load = 1'b1;
            cnt_val  = HW_LD;
          end else begin
            state_nx = DATA;
          end
        end
      end
      VS: begin
        if (cnt_tc) begin
          if (HSYNC_DELAY > 0) begin
            state_nx = HW;
            cnt_load = 1'b1;
            cnt_val  = HW_LD;
          end else begin
            state_nx = DATA;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      HW: begin
        if (cnt_tc) state_nx = DATA;
        else        cnt_en   = 1'b1;
      end
      DATA: begin
        if (accept) begin
          wm_nx = (wm_idx == WM_LAST) ? '0 : wm_idx + WW'(1);
          if (col == COL_LAST) begin
            col_nx = '0;
            if (row == ROW_LAST) begin
              state_nx = DONE;
            end else begin
              row_nx = row + RW'(1);
              if (HSYNC_DELAY > 0) begin
                state_nx = HW;
                cnt_load = 1'b1;
                cnt_val  = HW_LD;
              end
            end
          end else begin
            col_nx = col + COL_STEP;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        row_nx   = '0;
        col_nx   = '0;
        wm_nx    = '0;
      end
      default: state_nx = IDLE;
    endcase

    // Abort wins over every transition, including frame completion.
    if (abort) begin
      state_nx = IDLE;
      row_nx   = '0;
      col_nx   = '0;
      wm_nx    = '0;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      wm_idx    <= '0;
      busy      <= 1'b0;
      VSYNC     <= 1'b0;
      HSYNC     <= 1'b0;
      pix_valid <= 1'b0;
      embed_en  <= 1'b0;
      ctrl_done <= 1'b0;
    end else begin
      state     <= state_nx;
      row       <= row_nx;
      col       <= col_nx;
      wm_idx    <= wm_nx;
      busy      <= (state_nx != IDLE);
      VSYNC     <= (state_nx == VS);
      HSYNC     <= (state_nx == DATA);
      pix_valid <= (state_nx == DATA);
      embed_en  <= (state_nx == DATA);
      ctrl_done <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_wm_frame_seq.sv
// Bench for wm_frame_seq: queue-based frame model checked every cycle, directed timing literals,
// a degenerate-geometry instance, and randomized start/stall/abort/reset traffic.
`timescale 1ns/1ps
module tb_wm_frame_seq;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int SUD = 3;
  localparam int HD  = 2;
  localparam int WMB = 5;

  localparam int K_VS   = 0;
  localparam int K_HW   = 1;
  localparam int K_PAIR = 2;
  localparam int K_DONE = 3;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic       start, abort, out_ready;
  logic       busy, VSYNC, HSYNC, pix_valid, embed_en, ctrl_done;
  logic [1:0] row;
  logic [2:0] col;
  logic [2:0] wm_idx;

  logic       start2, abort2, out_ready2;
  logic       busy2, vsync2, hsync2, pv2, embed2, done2;
  logic [0:0] row2, col2;
  logic [2:0] wm2;

  always #5 HCLK = ~HCLK;

  wm_frame_seq #(
    .WIDTH(W), .HEIGHT(H), .START_UP_DELAY(SUD), .HSYNC_DELAY(HD), .WM_BITS(WMB)
  ) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .abort(abort), .out_ready(out_ready),
    .busy(busy), .VSYNC(VSYNC), .HSYNC(HSYNC), .pix_valid(pix_valid), .row(row), .col(col),
    .wm_idx(wm_idx), .embed_en(embed_en), .ctrl_done(ctrl_done)
  );

  wm_frame_seq #(
    .WIDTH(2), .HEIGHT(1), .START_UP_DELAY(3), .HSYNC_DELAY(0), .WM_BITS(5)
  ) u_edge (
    .HCLK(HCLK), .HRESET(HRESET), .start(start2), .abort(abort2), .out_ready(out_ready2),
    .busy(busy2), .VSYNC(vsync2), .HSYNC(hsync2), .pix_valid(pv2), .row(row2), .col(col2),
    .wm_idx(wm2), .embed_en(embed2), .ctrl_done(done2)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a queue of slots; the head slot defines the outputs.
  typedef struct {
    int kind;
    int r;
    int c;
    int w;
  } item_t;
  item_t q[$];

  task automatic build_frame();
    item_t it;
    int    w;
    w = 0;
    for (int i = 0; i < SUD; i++) begin it = '{K_VS, 0, 0, 0}; q.push_back(it); end
    for (int r = 0; r < H; r++) begin
      for (int i = 0; i < HD; i++) begin it = '{K_HW, r, 0, 0}; q.push_back(it); end
      for (int c = 0; c < W; c += 2) begin
        it = '{K_PAIR, r, c, w % WMB};
        q.push_back(it);
        w++;
      end
    end
    it = '{K_DONE, 0, 0, 0};
    q.push_back(it);
  endtask

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                                 q.delete();
    else if (abort)                             q.delete();
    else if (q.size() == 0) begin
      if (start) build_frame();
    end else if (q[0].kind != K_PAIR || out_ready) void'(q.pop_front());
  end

  always @(negedge HCLK) begin
    item_t h;
    if (q.size() == 0) begin
      chk("idle_busy", int'(busy), 0);
      chk("idle_vsync", int'(VSYNC), 0);
      chk("idle_hsync", int'(HSYNC), 0);
      chk("idle_pix_valid", int'(pix_valid), 0);
      chk("idle_embed_en", int'(embed_en), 0);
      chk("idle_ctrl_done", int'(ctrl_done), 0);
      chk("idle_row", int'(row), 0);
      chk("idle_col", int'(col), 0);
      chk("idle_wm_idx", int'(wm_idx), 0);
    end else begin
      h = q[0];
      chk("busy", int'(busy), 1);
      chk("vsync", int'(VSYNC), int'(h.kind == K_VS));
      chk("hsync", int'(HSYNC), int'(h.kind == K_PAIR));
      chk("pix_valid", int'(pix_valid), int'(h.kind == K_PAIR));
      chk("embed_en", int'(embed_en), int'(h.kind == K_PAIR));
      chk("ctrl_done", int'(ctrl_done), int'(h.kind == K_DONE));
      if (h.kind == K_PAIR) begin
        chk("row", int'(row), h.r);
        chk("col", int'(col), h.c);
        chk("wm_idx", int'(wm_idx), h.w);
      end
    end
  end

  int vs_a[64], pv_a[64], row_a[64], col_a[64], wm_a[64], dn_a[64], bz_a[64];

  // Caller is at a negedge (cycle 0); start is high for cycle 0 only.
  task automatic run_frame(input int stall_lo, input int stall_hi, input int restart_at,
                           input int abort_at, input int ncyc);
    start     = 1'b1;
    abort     = 1'b0;
    out_ready = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge HCLK);
      vs_a[n]  = int'(VSYNC);
      pv_a[n]  = int'(pix_valid);
      row_a[n] = int'(row);
      col_a[n] = int'(col);
      wm_a[n]  = int'(wm_idx);
      dn_a[n]  = int'(ctrl_done);
      bz_a[n]  = int'(busy);
      start     = (n == restart_at);
      abort     = (n == abort_at);
      out_ready = !(n >= stall_lo && n <= stall_hi);
    end
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
  endtask

  function automatic int first_done(input int ncyc);
    for (int n = 1; n <= ncyc; n++) if (dn_a[n] != 0) return n;
    return -1;
  endfunction

  function automatic int count_done(input int ncyc);
    int k;
    k = 0;
    for (int n = 1; n <= ncyc; n++) k += dn_a[n];
    return k;
  endfunction

  int vs2_a[16], pv2_a[16], hs2_a[16], em2_a[16], dn2_a[16], bz2_a[16], rc2_a[16], wm2_a[16];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rst_hold;
    start      = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b1;
    start2     = 1'b0;
    abort2     = 1'b0;
    out_ready2 = 1'b1;
    HRESET     = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_vsync", int'(VSYNC), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_ctrl_done", int'(ctrl_done), 0);
    chk("rst_wm_idx", int'(wm_idx), 0);
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("busy_after_release", int'(busy), 0);

    // Nominal frame
    run_frame(100, 0, -1, -1, 32);
    chk("nom_vsync_c1", vs_a[1], 1);
    chk("nom_vsync_c3", vs_a[3], 1);
    chk("nom_vsync_c4", vs_a[4], 0);
    chk("nom_pv_c5", pv_a[5], 0);
    chk("nom_pv_c6", pv_a[6], 1);
    chk("nom_col_c6", col_a[6], 0);
    chk("nom_col_c9", col_a[9], 6);
    chk("nom_wm_c9", wm_a[9], 3);
    chk("nom_pv_c10", pv_a[10], 0);
    chk("nom_row_c12", row_a[12], 1);
    chk("nom_wm_c12", wm_a[12], 4);
    chk("nom_wm_c13", wm_a[13], 0);
    chk("nom_last_pv_c27", pv_a[27], 1);
    chk("nom_last_wm_c27", wm_a[27], 0);
    chk("nom_done_cycle", first_done(32), 28);
    chk("nom_done_count", count_done(32), 1);
    chk("nom_busy_c28", bz_a[28], 1);
    chk("nom_busy_c29", bz_a[29], 0);

    // Stall cycles 7..9
    run_frame(7, 9, -1, -1, 34);
    chk("stall_pv_c8", pv_a[8], 1);
    chk("stall_row_c8", row_a[8], 0);
    chk("stall_col_c8", col_a[8], 2);
    chk("stall_wm_c8", wm_a[8], 1);
    chk("stall_col_c10", col_a[10], 2);
    chk("stall_col_c11", col_a[11], 4);
    chk("stall_done_cycle", first_done(34), 31);

    // Start while busy
    run_frame(100, 0, 10, -1, 32);
    chk("rebusy_done_cycle", first_done(32), 28);
    chk("rebusy_done_count", count_done(32), 1);

    // Abort at cycle 12
    run_frame(100, 0, -1, 12, 32);
    chk("abort_busy_c12", bz_a[12], 1);
    chk("abort_busy_c13", bz_a[13], 0);
    chk("abort_pv_c13", pv_a[13], 0);
    chk("abort_done_count", count_done(32), 0);

    // Asynchronous reset mid-DATA, then a fresh frame
    run_frame(100, 0, -1, -1, 14);
    chk("prerst_pv_c14", pv_a[14], 1);
    #2 HRESET = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pix_valid", int'(pix_valid), 0);
    chk("midrst_col", int'(col), 0);
    @(negedge HCLK);
    HRESET = 1'b0;
    run_frame(100, 0, -1, -1, 32);
    chk("postrst_wm_c6", wm_a[6], 0);
    chk("postrst_pv_c6", pv_a[6], 1);
    chk("postrst_done_cycle", first_done(32), 28);

    // Degenerate geometry: one row of one pair, no HSYNC blanking
    start2 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge HCLK);
      vs2_a[n] = int'(vsync2);
      pv2_a[n] = int'(pv2);
      hs2_a[n] = int'(hsync2);
      em2_a[n] = int'(embed2);
      dn2_a[n] = int'(done2);
      bz2_a[n] = int'(busy2);
      rc2_a[n] = int'(row2) + 2 * int'(col2);
      wm2_a[n] = int'(wm2);
      start2 = 1'b0;
    end
    chk("edge_vsync_c3", vs2_a[3], 1);
    chk("edge_pv_c3", pv2_a[3], 0);
    chk("edge_pv_c4", pv2_a[4], 1);
    chk("edge_hsync_c4", hs2_a[4], 1);
    chk("edge_embed_c4", em2_a[4], 1);
    chk("edge_rowcol_c4", rc2_a[4], 0);
    chk("edge_wm_c4", wm2_a[4], 0);
    chk("edge_pv_c5", pv2_a[5], 0);
    chk("edge_done_c4", dn2_a[4], 0);
    chk("edge_done_c5", dn2_a[5], 1);
    chk("edge_busy_c5", bz2_a[5], 1);
    chk("edge_busy_c6", bz2_a[6], 0);

    // Randomized start / stall / abort / reset traffic
    rst_hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge HCLK);
      if (rst_hold) begin
        HRESET   = 1'b0;
        rst_hold = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 HRESET = 1'b1;
        rst_hold  = 1'b1;
      end
    end
    @(negedge HCLK);
    HRESET    = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    @(negedge HCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wm_frame_seq.md
Name: wm_frame_seq

Overview:
- Frame-level sequencer for the watermark pixel datapath.
- On a start pulse it generates VSYNC/HSYNC timing and walks the image two pixels per cycle.
- For each accepted pixel pair it issues the row/column coordinates plus a watermark bit index and embed enable, then pulses ctrl_done at frame end.
- Sits between the top-level control and the image read / LSB-embed datapath, replacing free-running timing with a start/stall/abort-capable controller.

Parameters:
- WIDTH, 768, image width in pixels; must be even (simulation-time error otherwise).
- HEIGHT, 512, image height in rows.
- START_UP_DELAY, 100, cycles VSYNC is held high before the first row.
- HSYNC_DELAY, 160, blanking cycles before each row.
- WM_BITS, 64, watermark length in bits; wm_idx wraps modulo this.

Ports:
- HCLK  in  1  system clock, rising edge.
- HRESET  in  1  asynchronous active-high reset.
- start  in  1  one-cycle frame start request; sampled only in IDLE.
- abort  in  1  synchronous abort; any state returns to IDLE next cycle.
- out_ready  in  1  downstream accepts the current pixel pair this cycle.
- busy  out  1  high in every state except IDLE.
- VSYNC  out  1  high during the start-up delay.
- HSYNC  out  1  high while streaming row data (DATA state).
- pix_valid  out  1  current row/col pair is valid.
- row  out  $clog2(HEIGHT)  current row, 0..HEIGHT-1.
- col  out  $clog2(WIDTH)  even column of current pair, 0..WIDTH-2.
- wm_idx  out  $clog2(WM_BITS)  watermark bit index for current pair.
- embed_en  out  1  equals pix_valid; embed wm bit into this pair.
- ctrl_done  out  1  one-cycle pulse on frame completion.

Behaviour:
- Reset (async, HRESET=1): state IDLE; all outputs 0; all counters 0.
- IDLE: start=1 goes to VS. Delay counter and wm_idx are cleared; row=0, col=0.
- VS: VSYNC=1 for exactly START_UP_DELAY cycles, then HW.
- HW: HSYNC=0, pix_valid=0 for exactly HSYNC_DELAY cycles, then DATA. HSYNC_DELAY=0 goes straight to DATA.
- DATA: HSYNC=1, pix_valid=1. A pair is accepted when pix_valid and out_ready.
  - On accept: col+=2 and wm_idx=(wm_idx==WM_BITS-1)?0:wm_idx+1.
  - On the last pair of a row (col==WIDTH-2): col=0, then either row+=1 and go to HW, or (row==HEIGHT-1) go to DONE.
- Stall: out_ready=0 holds row, col, wm_idx and pix_valid stable. Valid must never drop without acceptance.
- DONE: ctrl_done=1 for one cycle, busy=1, then IDLE.
- Latency with out_ready always 1 and start sampled at cycle 0:
  - VSYNC high at cycles 1..START_UP_DELAY.
  - ctrl_done at cycle 1+START_UP_DELAY+HEIGHT*(HSYNC_DELAY+WIDTH/2).
- start while busy: ignored, no effect.
- abort: has priority over all transitions, including DONE and simultaneous accept. Next cycle is IDLE, outputs 0, no ctrl_done.
- abort and start in the same cycle in IDLE: stay IDLE.
- HRESET mid-frame: immediate IDLE. The next frame starts with wm_idx=0.
- wm_idx carries across rows and wraps continuously. It restarts at 0 only on a new frame.
- All outputs are registered; no combinational path from inputs to outputs except none.

Decomposition:
- Package wm_seq_pkg: state enum (IDLE, VS, HW, DATA, DONE) and width helper functions/localparams derived from WIDTH/HEIGHT/WM_BITS.
- One sub-module, wm_delay_cnt: loadable down-counter with terminal-count flag, shared by the VS and HW states.

Test Plan:
Use WIDTH=8, HEIGHT=4, START_UP_DELAY=3, HSYNC_DELAY=2, WM_BITS=5 unless noted.
- Reset: assert HRESET with no clock edge. All outputs 0 immediately; busy=0 after release.
- Nominal frame: start at cycle 0, out_ready=1.
  - VSYNC=1 cycles 1..3.
  - Row 0 pix_valid cycles 6..9 with col 0,2,4,6; row 1 at cycles 12..15.
  - wm_idx sequence 0,1,2,3,4,0,…; last pair has wm_idx=0.
  - ctrl_done single pulse at cycle 28.
- Stall: out_ready=0 cycles 7..9. row=0, col=2, wm_idx=1 held with pix_valid=1; ctrl_done moves to cycle 31.
- Start while busy: pulse start at cycle 10. No restart; done still at 28. Abort at cycle 12: IDLE at 13, busy=0, ctrl_done never asserted.
- Reset mid-DATA at cycle 14, then a new start: wm_idx begins at 0 and the frame completes normally 28 cycles after start.
- Edge parameters: HSYNC_DELAY=0, WIDTH=2, HEIGHT=1. One pair accepted at cycle 4, ctrl_done at cycle 5.
